dm_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters.
//  - Port 0: CPU M-stage.
//  - Port 1: debug/DMA loader.
//  CPU has fixed priority, with a starvation guard and a bounded burst lock for port 1.

---
 rtl/dm_port_arbiter_if.sv | 53 +++++
 rtl/dm_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if
//   Groups the two requester ports and the data-memory bus of the port arbiter.
//   Port 0 (CPU M-stage): req0/we0/addr0/wdata0/pc0 in; gnt0/stall0/rvalid0/rdata0/err0 out.
//   Port 1 (debug/DMA):   req1/we1/lock1/addr1/wdata1 in; gnt1/rvalid1/rdata1/err1 out.
//   Memory side:          dm_addr/dm_wdata/dm_we/dm_pc out; dm_rdata in (async read).
//   slave  : the arbiter's view.
//   master : the requesters' and memory's view.
interface dm_port_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic [31:0] pc0;
  logic        gnt0;
  logic        stall0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        err0;

  logic        req1;
  logic        we1;
  logic        lock1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        err1;

  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, pc0,
    input  req1, we1, lock1, addr1, wdata1,
    input  dm_rdata,
    output gnt0, stall0, rvalid0, rdata0, err0,
    output gnt1, rvalid1, rdata1, err1,
    output dm_addr, dm_wdata, dm_we, dm_pc
  );

  modport master (
    output req0, we0, addr0, wdata0, pc0,
    output req1, we1, lock1, addr1, wdata1,
    output dm_rdata,
    input  gnt0, stall0, rvalid0, rdata0, err0,
    input  gnt1, rvalid1, rdata1, err1,
    input  dm_addr, dm_wdata, dm_we, dm_pc
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares a single-port data memory between the CPU M-stage (port 0) and a
//   debug/DMA loader (port 1). Port 0 has fixed priority; port 1 is protected by
//   a starvation guard (MAX_WAIT) and may hold the memory for a bounded burst
//   (LOCK_MAX) with lock1. Grants are combinational, responses are registered
//   one cycle after the grant.
//   Ports: clk, reset (synchronous, active-high), bus (dm_port_arbiter_if.slave).
module dm_port_arbiter #(
  parameter int          MAX_WAIT   = 4,
  parameter int          LOCK_MAX   = 8,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               reset,
  dm_port_arbiter_if.slave   bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  // State names the port granted in the previous cycle.
  typedef enum logic [1:0] {IDLE, P0, P1, P1_LOCK} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic              lock_hold;
  logic [1:0]        gnt;
  logic [1:0]        we;
  logic [1:0]        illegal;
  logic [31:0]       addr [2];

  assign we      = {bus.we1, bus.we0};
  assign addr[0] = bus.addr0;
  assign addr[1] = bus.addr1;

  // Arbitration and next-state logic.
  always_comb begin
    gnt           = 2'b00;
    lock_hold     = 1'b0;
    state_next    = IDLE;
    wait_cnt_next = '0;
    lock_cnt_next = '0;
    if (!reset) begin
      // A running lock keeps port 1 until lock1 drops or the burst budget is spent.
      lock_hold = (state_reg == P1_LOCK) && bus.req1 && bus.lock1 &&
                  (lock_cnt_reg < LOCK_W'(LOCK_MAX));
      if (lock_hold || (bus.req1 && (wait_cnt_reg == WAIT_W'(MAX_WAIT)))) begin
        gnt[1] = 1'b1;
      end else if (bus.req0) begin
        gnt[0] = 1'b1;
      end else if (bus.req1) begin
        gnt[1] = 1'b1;
      end

      if (gnt[0]) begin
        state_next = P0;
      end else if (gnt[1]) begin
        state_next = bus.lock1 ? P1_LOCK : P1;
      end

      if (bus.req1 && !gnt[1]) begin
        wait_cnt_next = (wait_cnt_reg == WAIT_W'(MAX_WAIT)) ? wait_cnt_reg
                                                            : wait_cnt_reg + WAIT_W'(1);
      end

      // A locked grant that is not a continuation (fresh entry, or the one
      // arbitration after the budget ran out) starts a new burst at 1.
      if (gnt[1] && bus.lock1) begin
        lock_cnt_next = lock_hold ? lock_cnt_reg + LOCK_W'(1) : LOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Memory-side mux: everything is zero when nobody owns the memory, and
  // illegal accesses never write.
  always_comb begin
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_we    = 1'b0;
    bus.dm_pc    = '0;
    if (gnt[0]) begin
      bus.dm_addr  = bus.addr0;
      bus.dm_wdata = bus.wdata0;
      bus.dm_we    = bus.we0 && !illegal[0];
      bus.dm_pc    = bus.pc0;
    end else if (gnt[1]) begin
      bus.dm_addr  = bus.addr1;
      bus.dm_wdata = bus.wdata1;
      bus.dm_we    = bus.we1 && !illegal[1];
    end
  end

  // Per-port legality check and registered response.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic        rvalid_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    assign illegal[gi] = (addr[gi][1:0] != 2'b00) || (addr[gi] >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt[gi];
        err_reg    <= gnt[gi] && illegal[gi];
        // rdata holds between responses; writes and errors return zero.
        if (gnt[gi]) begin
          rdata_reg <= (illegal[gi] || we[gi]) ? 32'h0 : bus.dm_rdata;
        end
      end
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.stall0  = bus.req0 && !gnt[0];
  assign bus.rvalid0 = g_port[0].rvalid_reg;
  assign bus.err0    = g_port[0].err_reg;
  assign bus.rdata0  = g_port[0].rdata_reg;
  assign bus.rvalid1 = g_port[1].rvalid_reg;
  assign bus.err1    = g_port[1].err_reg;
  assign bus.rdata1  = g_port[1].rdata_reg;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Drives both requester ports from a stimulus process, predicts grants and
//   memory-side values from a behavioural model, and queues the expected
//   responses; a monitor on the falling edge pops and compares them.
module tb_dm_port_arbiter;

  localparam int          MAX_WAIT   = 4;
  localparam int          LOCK_MAX   = 8;
  localparam logic [31:0] ADDR_LIMIT = 32'h0000_3000;
  localparam int          MEM_WORDS  = 3072;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(
    .MAX_WAIT  (MAX_WAIT),
    .LOCK_MAX  (LOCK_MAX),
    .ADDR_LIMIT(ADDR_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          active;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } req_t;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  bit          prev_rst = 1'b1;
  resp_t       q0[$];
  resp_t       q1[$];
  logic [31:0] hold [2];
  logic [31:0] phys_mem [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  req_t        p0, p1;
  bit          lk1;
  int          act_g;

  // Model state: consecutive denied cycles of port 1, whether port 1 holds a
  // lock from last cycle, and how many locked grants the current burst has had.
  int m_wait, m_run;
  bit m_locked;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
  endfunction

  // Data memory: async read, write on the rising edge.
  assign bus.dm_rdata = (bus.dm_addr < ADDR_LIMIT) ? phys_mem[bus.dm_addr[13:2]] : 32'h0;
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) phys_mem[i] <= init_word(i);
    forever begin
      @(posedge clk);
      if (bus.dm_we && (bus.dm_addr < ADDR_LIMIT)) phys_mem[bus.dm_addr[13:2]] <= bus.dm_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon_port(input int p, input logic rv, input logic er, input logic [31:0] rd);
    resp_t e;
    bit    have;
    have = 1'b0;
    if (p == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (p == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (rv) begin
      if (!have) begin
        chk($sformatf("unexpected_rvalid%0d", p), {31'b0, rv}, 32'h0);
      end else begin
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("resp%0d_cycle", p), cyc, e.due);
        chk($sformatf("err%0d", p), {31'b0, er}, {31'b0, e.err});
        chk($sformatf("rdata%0d", p), rd, e.rdata);
        hold[p] = e.rdata;
        $display("resp port%0d cycle %0d err=%0b rdata=%08h", p, cyc, er, rd);
      end
    end else begin
      chk($sformatf("err%0d_idle", p), {31'b0, er}, 32'h0);
      if (have && e.due <= cyc) begin
        chk($sformatf("missing_rvalid%0d", p), {31'b0, rv}, 32'h1);
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      chk($sformatf("rdata%0d_hold", p), rd, hold[p]);
    end
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_rvalid0", {31'b0, bus.rvalid0}, 32'h0);
      chk("rst_rvalid1", {31'b0, bus.rvalid1}, 32'h0);
      chk("rst_err0", {31'b0, bus.err0}, 32'h0);
      chk("rst_err1", {31'b0, bus.err1}, 32'h0);
      chk("rst_rdata0", bus.rdata0, 32'h0);
      chk("rst_rdata1", bus.rdata1, 32'h0);
      hold[0] = 32'h0;
      hold[1] = 32'h0;
    end else begin
      mon_port(0, bus.rvalid0, bus.err0, bus.rdata0);
      mon_port(1, bus.rvalid1, bus.err1, bus.rdata1);
    end
    prev_rst = reset;
  end

  task automatic set_req(output req_t r, input bit we, input logic [31:0] a, input logic [31:0] d);
    r.active = 1'b1;
    r.we     = we;
    r.addr   = a;
    r.wdata  = d;
    r.pc     = $urandom;
  endtask

  task automatic rand_req(output req_t r);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = ADDR_LIMIT + ($urandom_range(0, 3) << 2);
      1:       a = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
      2:       a = ADDR_LIMIT - 32'd4;
      default: a = $urandom_range(0, 15) << 2;
    endcase
    set_req(r, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // One clock cycle: drive, predict, compare the combinational outputs, queue
  // the expected response, then advance to just after the next rising edge.
  task automatic run_cycle(input bit rst);
    int          g;
    bit          cont, lg;
    req_t        r;
    logic [31:0] e_addr, e_wdata, e_pc;
    bit          e_we;
    resp_t       e;

    reset      = rst;
    bus.req0   = p0.active;
    bus.we0    = p0.active ? p0.we    : 1'($urandom_range(0, 1));
    bus.addr0  = p0.active ? p0.addr  : $urandom;
    bus.wdata0 = p0.active ? p0.wdata : $urandom;
    bus.pc0    = p0.active ? p0.pc    : $urandom;
    bus.req1   = p1.active;
    bus.we1    = p1.active ? p1.we    : 1'($urandom_range(0, 1));
    bus.addr1  = p1.active ? p1.addr  : $urandom;
    bus.wdata1 = p1.active ? p1.wdata : $urandom;
    bus.lock1  = lk1;
    #1;

    g = -1;
    if (!rst) begin
      cont = m_locked && p1.active && lk1 && (m_run < LOCK_MAX);
      if (cont || (p1.active && m_wait >= MAX_WAIT)) g = 1;
      else if (p0.active) g = 0;
      else if (p1.active) g = 1;
    end

    act_g = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
    chk("gnt0", {31'b0, bus.gnt0}, {31'b0, g == 0});
    chk("gnt1", {31'b0, bus.gnt1}, {31'b0, g == 1});
    chk("stall0", {31'b0, bus.stall0}, {31'b0, p0.active && g != 0});

    e_addr = 32'h0; e_wdata = 32'h0; e_pc = 32'h0; e_we = 1'b0;
    if (g >= 0) begin
      r       = (g == 0) ? p0 : p1;
      lg      = legal(r.addr);
      e_addr  = r.addr;
      e_wdata = r.wdata;
      e_pc    = (g == 0) ? r.pc : 32'h0;
      e_we    = r.we && lg;
      e.due   = cyc + 1;
      e.err   = !lg;
      e.rdata = (lg && !r.we) ? ref_mem[r.addr[13:2]] : 32'h0;
      if (lg && r.we) ref_mem[r.addr[13:2]] = r.wdata;
      if (g == 0) q0.push_back(e); else q1.push_back(e);
      $display("grant port%0d cycle %0d we=%0b addr=%08h", g, cyc, r.we, r.addr);
    end
    chk("dm_we", {31'b0, bus.dm_we}, {31'b0, e_we});
    chk("dm_addr", bus.dm_addr, e_addr);
    chk("dm_wdata", bus.dm_wdata, e_wdata);
    chk("dm_pc", bus.dm_pc, e_pc);

    if (rst) begin
      m_wait = 0; m_locked = 1'b0; m_run = 0;
    end else begin
      if (g == 1 || !p1.active) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (g == 1 && lk1) begin
        m_run    = cont ? m_run + 1 : 1;
        m_locked = 1'b1;
      end else begin
        m_run    = 0;
        m_locked = 1'b0;
      end
    end
    if (g == 0) p0.active = 1'b0;
    if (g == 1) p1.active = 1'b0;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    p0.active = 1'b0; p1.active = 1'b0; lk1 = 1'b0;
    for (int i = 0; i < n; i++) run_cycle(1'b0);
  endtask

  initial begin
    int exp_wait [5];
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    p0 = '{default: 0};
    p1 = '{default: 0};
    lk1 = 1'b0;
    m_wait = 0; m_run = 0; m_locked = 1'b0;

    run_cycle(1'b1);
    run_cycle(1'b1);
    idle(1);

    // Single write from port 0.
    set_req(p0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    run_cycle(1'b0);
    chk("t_write_gnt", act_g, 0);
    idle(2);

    // Both ports read: port 1 wins once its wait count reaches MAX_WAIT.
    exp_wait = '{0, 0, 0, 0, 1};
    set_req(p1, 1'b0, 32'h44, 32'h0);
    for (int c = 0; c < 5; c++) begin
      set_req(p0, 1'b0, 32'h40, 32'h0);
      run_cycle(1'b0);
      chk($sformatf("wait_seq_%0d", c), act_g, exp_wait[c]);
    end
    idle(2);

    // Locked burst of port 1; port 0 asserted from the second cycle.
    lk1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      set_req(p1, 1'b0, 32'h48 + (c << 2), 32'h0);
      if (c >= 1) set_req(p0, 1'b0, 32'h4C, 32'h0);
      run_cycle(1'b0);
      if (c < 8) chk($sformatf("lock_seq_%0d", c), act_g, 1);
      else if (c == 8) chk("lock_release", act_g, 0);
    end
    idle(2);

    // Illegal reads from port 1.
    set_req(p1, 1'b0, ADDR_LIMIT, 32'h0);
    run_cycle(1'b0);
    set_req(p1, 1'b0, 32'h6, 32'h0);
    run_cycle(1'b0);
    idle(2);

    // Write via port 0, read back via port 1.
    set_req(p0, 1'b1, 32'h20, 32'h55);
    run_cycle(1'b0);
    set_req(p1, 1'b0, 32'h20, 32'h0);
    run_cycle(1'b0);
    idle(2);

    // Reset in the middle of a lock: the lock is abandoned.
    lk1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(p1, 1'b1, 32'h60, $urandom);
      run_cycle(1'b0);
    end
    set_req(p1, 1'b1, 32'h60, $urandom);
    run_cycle(1'b1);
    chk("reset_gnt1", act_g, -1);
    set_req(p0, 1'b0, 32'h64, 32'h0);
    run_cycle(1'b0);
    chk("post_reset_gnt", act_g, 0);
    idle(3);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if (!p0.active && $urandom_range(0, 2) == 0) rand_req(p0);
      if (!p1.active && $urandom_range(0, 2) == 0) rand_req(p1);
      if ($urandom_range(0, 7) == 0) lk1 = ~lk1;
      run_cycle($urandom_range(0, 199) == 0);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
